// File: rtl/mask_mul.sv
// mask_mul: first-order Boolean-masked GF(2^2) multiplier, poly x^2+x+1.
// Optional MASKMUL_PPREG_EN registers cross products and mq (latency 2).

module mask_mul_gf4 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [1:0] p
);

  // GF(4) product, bit 1 is the MSB
  always_comb begin
    p[1] = (x[1] & y[1]) ^ (x[1] & y[0]) ^ (x[0] & y[1]);
    p[0] = (x[1] & y[1]) ^ (x[0] & y[0]);
  end

endmodule

module mask_mul (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] am,
  input  logic [1:0] bm,
  input  logic [1:0] ma,
  input  logic [1:0] mb,
  input  logic [1:0] mq,
  output logic [1:0] qm
);

  logic [1:0] pp_ab;
  logic [1:0] pp_amb;
  logic [1:0] pp_mab;
  logic [1:0] pp_mm;

  logic [1:0] x_ab;
  logic [1:0] x_amb;
  logic [1:0] x_mab;
  logic [1:0] x_mm;
  logic [1:0] x_mq;

  logic [1:0] s0;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] t;

  logic [1:0] qm_d;
  logic [1:0] qm_q;

  mask_mul_gf4 u_ab (
    .x (am),
    .y (bm),
    .p (pp_ab)
  );

  mask_mul_gf4 u_amb (
    .x (am),
    .y (mb),
    .p (pp_amb)
  );

  mask_mul_gf4 u_mab (
    .x (ma),
    .y (bm),
    .p (pp_mab)
  );

  mask_mul_gf4 u_mm (
    .x (ma),
    .y (mb),
    .p (pp_mm)
  );

`ifdef MASKMUL_PPREG_EN
  logic [1:0] ab_d;
  logic [1:0] ab_q;
  logic [1:0] amb_d;
  logic [1:0] amb_q;
  logic [1:0] mab_d;
  logic [1:0] mab_q;
  logic [1:0] mm_d;
  logic [1:0] mm_q;
  logic [1:0] mq_d;
  logic [1:0] mq_q;

  // Next value of the glitch-isolation stage; reset clears it
  always_comb begin
    ab_d  = pp_ab;
    amb_d = pp_amb;
    mab_d = pp_mab;
    mm_d  = pp_mm;
    mq_d  = mq;
    if (reset) begin
      ab_d  = 2'b00;
      amb_d = 2'b00;
      mab_d = 2'b00;
      mm_d  = 2'b00;
      mq_d  = 2'b00;
    end
  end

  // Register cross products and fresh mask
  always_ff @(posedge clk) begin
    ab_q  <= ab_d;
    amb_q <= amb_d;
    mab_q <= mab_d;
    mm_q  <= mm_d;
    mq_q  <= mq_d;
  end

  assign x_ab  = ab_q;
  assign x_amb = amb_q;
  assign x_mab = mab_q;
  assign x_mm  = mm_q;
  assign x_mq  = mq_q;
`else
  assign x_ab  = pp_ab;
  assign x_amb = pp_amb;
  assign x_mab = pp_mab;
  assign x_mm  = pp_mm;
  assign x_mq  = mq;
`endif

  // Fixed XOR chain seeded with mq so no partial sum is unmasked
  always_comb begin
    s0 = x_mq ^ x_ab;
    s1 = s0 ^ x_amb;
    s2 = s1 ^ x_mab;
    t  = s2 ^ x_mm;
  end

  // Output register next value; reset overrides the chain
  always_comb begin
    qm_d = t;
    if (reset) begin
      qm_d = 2'b00;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    qm_q <= qm_d;
  end

  assign qm = qm_q;

endmodule

// File: tb/tb_mask_mul.sv
// tb_mask_mul: directed vectors plus random stream vs a GF(4) model.
// Latency follows MASKMUL_PPREG_EN (1 or 2 cycles).

module tb_mask_mul;

`ifdef MASKMUL_PPREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] am;
  logic [1:0] bm;
  logic [1:0] ma;
  logic [1:0] mb;
  logic [1:0] mq;
  logic [1:0] qm;

  int n_pass = 0;
  int n_tot  = 0;

  logic       chk_en = 1'b0;
  logic [1:0] exp_q  = 2'b00;
  logic [1:0] exp_s1 = 2'b00;

  mask_mul dut (
    .clk   (clk),
    .reset (reset),
    .am    (am),
    .bm    (bm),
    .ma    (ma),
    .mb    (mb),
    .mq    (mq),
    .qm    (qm)
  );

  always #5 clk = ~clk;

  // Polynomial multiply then reduce by x^2 = x + 1
  function automatic logic [1:0] gf4(input logic [1:0] x,
                                     input logic [1:0] y);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 2; i++)
      if (y[i]) r = r ^ ({1'b0, x} << i);
    if (r[2]) r = r ^ 3'b111;
    return r[1:0];
  endfunction

  task automatic chk(input string nm,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: qm=%b expected=%b at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference: product of unmasked operands, delayed by LAT
  always @(posedge clk) begin
    logic [1:0] v;
    v = gf4(am ^ ma, bm ^ mb) ^ mq;
    if (LAT == 2) begin
      exp_q  = reset ? 2'b00 : exp_s1;
      exp_s1 = reset ? 2'b00 : v;
    end else begin
      exp_q = reset ? 2'b00 : v;
    end
    if (reset) chk_en = 1'b1;
  end

  // Continuous compare away from the active edge
  always @(negedge clk) begin
    if (chk_en) chk("stream", qm, exp_q);
  end

  task automatic drive(input logic r, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] xa,
                       input logic [1:0] xb, input logic [1:0] xq);
    reset = r;
    am = a;
    bm = b;
    ma = xa;
    mb = xb;
    mq = xq;
  endtask

  // Directed vectors: am bm ma mb mq expected-qm
  logic [1:0] dv [7][6];

  initial begin
    dv[0] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    dv[1] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11};
    dv[2] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
    dv[3] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
    dv[4] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    dv[5] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10};
    dv[6] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01};

    drive(1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11);
    @(posedge clk);
    #1 chk("reset", qm, 2'b00);

    // a = 0 here, so the first result equals mq = 11
    reset = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk);
      #1;
      if (i < LAT - 1) chk("rel_pipe", qm, 2'b00);
    end
    chk("rel", qm, 2'b11);

    for (int i = 0; i < 7 + LAT - 1; i++) begin
      int k;
      k = (i < 7) ? i : 6;
      drive(1'b0, dv[k][0], dv[k][1], dv[k][2],
            dv[k][3], dv[k][4]);
      @(posedge clk);
      #1;
      if (i >= LAT - 1) begin
        chk($sformatf("dir%0d", i - LAT + 1), qm,
            dv[i - LAT + 1][5]);
        if (i - LAT + 1 == 5)
          chk("unmask", qm ^ 2'b11, 2'b01);
        if (i - LAT + 1 == 6)
          chk("zero_op", qm, 2'b01);
      end
    end

    for (int i = 0; i < 500; i++) begin
      drive((i == 250), 2'($urandom), 2'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom));
      @(posedge clk);
      #1;
      if (i == 250) chk("midrst", qm, 2'b00);
    end

    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
